// File: rtl/pattern_store.sv
// Pattern buffer loaded by a serial scan chain or addressed writes, read by PAT.
// Define PATTERN_STORE_SHADOW_EN to shift into a shadow chain committed in DONE.
module pattern_store #(
    parameter int DEPTH = 22,
    parameter int WIDTH = 8,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_start,
    input  logic             sin,
    output logic             sout,
    output logic             scan_busy,
    output logic             scan_done,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_err,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);

    localparam int NB = DEPTH * WIDTH;
    localparam int CW = $clog2(NB);
    localparam logic [AW:0] DEPTH_A = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NB-1:0]    act_q, act_d;
    logic             wr_err_q, wr_err_d;
    logic             rd_valid_q;
    logic [WIDTH-1:0] rd_data_q, rd_word;
    logic             wr_ok;

`ifdef PATTERN_STORE_SHADOW_EN
    logic [NB-1:0]    shd_q, shd_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (scan_start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (cnt_q == CW'(NB - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The commit owns the active array in DONE, so writes lose there.
`ifdef PATTERN_STORE_SHADOW_EN
    assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_A) && (state_q != DONE);
`else
    assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_A) && (state_q == IDLE);
`endif
    assign wr_err_d = wr_en && !wr_ok;

    always_comb begin
        act_d = act_q;
`ifdef PATTERN_STORE_SHADOW_EN
        shd_d = shd_q;
        if (state_q == SHIFT) begin
            shd_d = {shd_q[NB-2:0], sin};
        end
        if (state_q == DONE) begin
            act_d = shd_q;
        end
`else
        if (state_q == SHIFT) begin
            act_d = {act_q[NB-2:0], sin};
        end
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if (wr_ok && (wr_addr == AW'(k))) begin
                act_d[k*WIDTH +: WIDTH] = wr_data;
            end
        end
    end

    // Out-of-range addresses match no entry and read back as zero.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (rd_addr == AW'(k)) begin
                rd_word = act_q[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            act_q      <= '0;
            wr_err_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_q      <= act_d;
            wr_err_q   <= wr_err_d;
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= rd_word;
            end
        end
    end

`ifdef PATTERN_STORE_SHADOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_q <= '0;
        end else begin
            shd_q <= shd_d;
        end
    end

    assign sout = shd_q[NB-1];
`else
    assign sout = act_q[NB-1];
`endif

    assign scan_busy = (state_q == SHIFT);
    assign scan_done = (state_q == DONE);
    assign wr_err    = wr_err_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule
